// File: rtl/mc_d_mem_if.sv
// Requester-side bus of the multi-port data memory: per-port requests in,
// shared completion and read data back.
interface mc_d_mem_if #(
  parameter int DATA_W    = 64,
  parameter int WORD_W    = 16,
  parameter int ADDR_W    = 11,
  parameter int NUM_PORTS = 2
) ();
  logic [NUM_PORTS-1:0]                 re;
  logic [NUM_PORTS-1:0]                 we;
  logic [NUM_PORTS*ADDR_W-1:0]          addr;
  logic [NUM_PORTS*DATA_W-1:0]          wdata;
  logic [NUM_PORTS*(DATA_W/WORD_W)-1:0] wmask;
  logic [NUM_PORTS-1:0]                 ack;
  logic [DATA_W-1:0]                    rd_data;
  logic                                 busy;
  logic [2:0]                           gnt_id;

  modport master (
    output re, we, addr, wdata, wmask,
    input  ack, rd_data, busy, gnt_id
  );

  modport slave (
    input  re, we, addr, wdata, wmask,
    output ack, rd_data, busy, gnt_id
  );
endinterface

// File: rtl/mc_d_mem.sv
// Multi-port line memory: round-robin arbitration, one access at a time with a
// fixed LATENCY-cycle busy window, 16-bit lane write masks, per-port ack pulse.
module mc_d_mem #(
  parameter int DATA_W    = 64,
  parameter int WORD_W    = 16,
  parameter int DEPTH     = 2048,
  parameter int ADDR_W    = 11,
  parameter int NUM_PORTS = 2,
  parameter int LATENCY   = 4
) (
  input  logic       clk,
  input  logic       rst,
  mc_d_mem_if.slave  bus
);
  localparam int LANES  = DATA_W / WORD_W;
  localparam int CNT_W  = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam int AIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] CNT_ACC  = CNT_W'(LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [2:0]       LAST_RST = 3'(NUM_PORTS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [2:0]           last_gnt;
  logic [2:0]           gnt_id;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] ack;

  logic                 win_vld;
  logic [2:0]           win;
  logic [ADDR_W-1:0]    win_addr;
  logic [DATA_W-1:0]    win_wdata;
  logic [LANES-1:0]     win_wmask;
  logic                 win_we;

  logic [ADDR_W-1:0]    cap_addr;
  logic [DATA_W-1:0]    cap_wdata;
  logic [LANES-1:0]     cap_wmask;
  logic                 cap_we;

  logic                 acc_en;
  logic                 in_range;
  logic [AIDX_W-1:0]    aidx;
  logic [DATA_W-1:0]    rd_data;
  logic [DATA_W-1:0]    mem [0:DEPTH-1];

  // Arbitration: rotate priority starting one past the last grant
  always_comb begin
    req       = bus.re | bus.we;
    win_vld   = 1'b0;
    win       = '0;
    win_addr  = '0;
    win_wdata = '0;
    win_wmask = '0;
    win_we    = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!win_vld && req[p] &&
            ((int'(last_gnt) + i == p) || (int'(last_gnt) + i == p + NUM_PORTS))) begin
          win_vld   = 1'b1;
          win       = 3'(p);
          win_addr  = bus.addr[p*ADDR_W +: ADDR_W];
          win_wdata = bus.wdata[p*DATA_W +: DATA_W];
          win_wmask = bus.wmask[p*LANES +: LANES];
          win_we    = bus.we[p];
        end
      end
    end
  end

  // Control FSM: next state, counter and outputs
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack       = '0;
    acc_en    = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = BUSY;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        acc_en = (cnt == CNT_ACC);
        if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (3'(p) == last_gnt) ack[p] = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last_gnt <= LAST_RST;
      gnt_id   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && win_vld) begin
        last_gnt <= win;
        gnt_id   <= win;
      end
    end
  end

  // Capture stage: winner's request held for the whole access
  always_ff @(posedge clk) begin
    if (state == IDLE && win_vld) begin
      cap_addr  <= win_addr;
      cap_wdata <= win_wdata;
      cap_wmask <= win_wmask;
      cap_we    <= win_we;
    end
  end

  assign in_range = ({1'b0, cap_addr} < DEPTH_L);
  assign aidx     = cap_addr[AIDX_W-1:0];

  // Access stage: lane-masked write; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (!rst && acc_en && cap_we && in_range) begin
      for (int l = 0; l < LANES; l++) begin
        if (cap_wmask[l]) mem[aidx][l*WORD_W +: WORD_W] <= cap_wdata[l*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (acc_en && !cap_we) begin
      rd_data <= in_range ? mem[aidx] : '0;
    end
  end

  assign bus.ack     = ack;
  assign bus.rd_data = rd_data;
  assign bus.busy    = (state == BUSY);
  assign bus.gnt_id  = gnt_id;
endmodule

// File: tb/tb_mc_d_mem.sv
// Directed bench for mc_d_mem: vector table of single accesses plus hand
// sequences for reset, round-robin arbitration and reset during an access.
module tb_mc_d_mem;
  localparam int DW = 64;
  localparam int WW = 16;
  localparam int DP = 1000;
  localparam int AW = 11;
  localparam int NP = 2;
  localparam int LT = 4;
  localparam int MW = DW / WW;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  mc_d_mem_if #(.DATA_W(DW), .WORD_W(WW), .ADDR_W(AW), .NUM_PORTS(NP)) bus ();

  mc_d_mem #(
    .DATA_W(DW), .WORD_W(WW), .DEPTH(DP), .ADDR_W(AW), .NUM_PORTS(NP), .LATENCY(LT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          port;
    logic        w;
    logic        r;
    logic [10:0] a;
    logic [63:0] d;
    logic [3:0]  m;
    logic [63:0] exp_rd;
    bit          chk_rd;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    bus.re    = '0;
    bus.we    = '0;
  endtask

  task automatic access(input int p, input logic w, input logic r, input logic [10:0] a,
                        input logic [63:0] d, input logic [3:0] m,
                        input logic [63:0] exp_rd, input bit chk_rd, input string nm);
    int lat;
    bit got;
    @(negedge clk);
    idle_inputs();
    bus.we[p]              = w;
    bus.re[p]              = r;
    bus.addr[p*AW +: AW]   = a;
    bus.wdata[p*DW +: DW]  = d;
    bus.wmask[p*MW +: MW]  = m;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.ack != '0) got = 1'b1;
    end
    chk({nm, " latency"}, 64'(lat), 64'(LT));
    chk({nm, " ack"}, 64'(bus.ack), 64'(1 << p));
    chk({nm, " gnt_id"}, 64'(bus.gnt_id), 64'(p));
    chk({nm, " busy"}, 64'(bus.busy), 64'd1);
    if (chk_rd) chk({nm, " rd_data"}, bus.rd_data, exp_rd);
    idle_inputs();
  endtask

  initial begin
    int ack_n;
    int last_cyc;
    int cyc;
    bit stray;

    vecs[0]  = '{0, 1'b1, 1'b0, 11'h010,  64'h1111_2222_3333_4444, 4'hF, 64'h0, 1'b0};
    vecs[1]  = '{0, 1'b0, 1'b1, 11'h010,  64'h0,                   4'h0, 64'h1111_2222_3333_4444, 1'b1};
    vecs[2]  = '{1, 1'b1, 1'b0, 11'h010,  64'hAAAA_BBBB_CCCC_DDDD, 4'b0101, 64'h1111_2222_3333_4444, 1'b1};
    vecs[3]  = '{1, 1'b0, 1'b1, 11'h010,  64'h0,                   4'h0, 64'h1111_BBBB_3333_DDDD, 1'b1};
    vecs[4]  = '{0, 1'b1, 1'b0, 11'h020,  64'h5555_6666_7777_8888, 4'hF, 64'h1111_BBBB_3333_DDDD, 1'b1};
    vecs[5]  = '{1, 1'b1, 1'b0, 11'h1DC,  64'h0F0F_0F0F_0F0F_0F0F, 4'hF, 64'h1111_BBBB_3333_DDDD, 1'b1};
    vecs[6]  = '{0, 1'b1, 1'b0, 11'd1500, 64'hDEAD_BEEF_DEAD_BEEF, 4'hF, 64'h1111_BBBB_3333_DDDD, 1'b1};
    vecs[7]  = '{0, 1'b0, 1'b1, 11'd1500, 64'h0,                   4'h0, 64'h0, 1'b1};
    vecs[8]  = '{1, 1'b0, 1'b1, 11'h1DC,  64'h0,                   4'h0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1};
    vecs[9]  = '{0, 1'b1, 1'b1, 11'h030,  64'h0123_4567_89AB_CDEF, 4'hF, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1};
    vecs[10] = '{1, 1'b0, 1'b1, 11'h030,  64'h0,                   4'h0, 64'h0123_4567_89AB_CDEF, 1'b1};
    vecs[11] = '{0, 1'b1, 1'b0, 11'h030,  64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 64'h0123_4567_89AB_CDEF, 1'b1};
    vecs[12] = '{1, 1'b0, 1'b1, 11'h030,  64'h0,                   4'h0, 64'h0123_4567_89AB_CDEF, 1'b1};

    bus.addr  = '0;
    bus.wdata = '0;
    bus.wmask = '0;
    idle_inputs();

    // Reset held two cycles with a pending port-0 read
    rst       = 1'b1;
    bus.re[0] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("reset ack", 64'(bus.ack), 64'd0);
      chk("reset busy", 64'(bus.busy), 64'd0);
      chk("reset rd_data", bus.rd_data, 64'd0);
      chk("reset gnt_id", 64'(bus.gnt_id), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset accept busy", 64'(bus.busy), 64'd1);
    chk("post-reset accept gnt_id", 64'(bus.gnt_id), 64'd0);
    cyc = 1;
    while (bus.ack == '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("post-reset latency", 64'(cyc), 64'(LT));
    chk("post-reset ack", 64'(bus.ack), 64'd1);
    idle_inputs();

    for (int i = 0; i < 13; i++) begin
      access(vecs[i].port, vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].m,
             vecs[i].exp_rd, vecs[i].chk_rd, $sformatf("vec%0d", i));
    end

    // Both ports request continuously; last grant was port 1
    @(negedge clk);
    bus.addr[0*AW +: AW] = 11'h010;
    bus.addr[1*AW +: AW] = 11'h020;
    bus.we = '0;
    bus.re = 2'b11;
    ack_n = 0;
    last_cyc = 0;
    cyc = 0;
    while (ack_n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.ack != '0) begin
        chk($sformatf("arb ack%0d onehot", ack_n), 64'($onehot(bus.ack)), 64'd1);
        chk($sformatf("arb ack%0d port", ack_n), 64'(bus.ack), 64'((ack_n % 2 == 0) ? 1 : 2));
        chk($sformatf("arb ack%0d gnt_id", ack_n), 64'(bus.gnt_id), 64'(ack_n % 2));
        chk($sformatf("arb ack%0d rd_data", ack_n), bus.rd_data,
            (ack_n % 2 == 0) ? 64'h1111_BBBB_3333_DDDD : 64'h5555_6666_7777_8888);
        if (ack_n > 0) chk($sformatf("arb ack%0d spacing", ack_n), 64'(cyc - last_cyc), 64'(LT + 1));
        last_cyc = cyc;
        ack_n++;
      end
    end
    chk("arb ack count", 64'(ack_n), 64'd4);
    idle_inputs();

    // Reset during a write to 0x020, asserted in the cnt==2 cycle
    @(negedge clk);
    bus.we[0]            = 1'b1;
    bus.addr[0*AW +: AW] = 11'h020;
    bus.wdata[0*DW +: DW] = 64'h9999_9999_9999_9999;
    bus.wmask[0*MW +: MW] = 4'hF;
    repeat (3) @(negedge clk);
    chk("abort busy before rst", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk("abort ack", 64'(bus.ack), 64'd0);
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort rd_data", bus.rd_data, 64'd0);
    rst = 1'b0;
    stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.ack != '0 || bus.busy) stray = 1'b1;
    end
    chk("abort no later ack", 64'(stray), 64'd0);
    access(0, 1'b0, 1'b1, 11'h020, 64'h0, 4'h0, 64'h5555_6666_7777_8888, 1'b1, "abort readback");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mc_d_mem.md
# mc_d_mem

Multi-port, parametrised data memory for the multicore build. It serves NUM_PORTS cache/core requesters through round-robin arbitration and completes one access at a time with a fixed multi-cycle latency. Writes are masked per 16-bit lane, reads return a full cache line, and each requester gets a per-port completion pulse. It sits below the per-core caches and replaces the single-requester, fixed-size data memory.

## Interface

- DATA_W, 64: line width in bits; must be a multiple of WORD_W.
- WORD_W, 16: write-mask lane width.
- DEPTH, 2048: number of lines.
- ADDR_W, 11: line address width; DEPTH ≤ 2^ADDR_W.
- NUM_PORTS, 2: requester count, 1..8.
- LATENCY, 4: cycles in BUSY, minimum 2.

Ports (clock and reset first):

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- re  in  NUM_PORTS  per-port read request.
- we  in  NUM_PORTS  per-port write request.
- addr  in  NUM_PORTS*ADDR_W  per-port line address; port p uses slice [p*ADDR_W +: ADDR_W].
- wdata  in  NUM_PORTS*DATA_W  per-port write data.
- wmask  in  NUM_PORTS*(DATA_W/WORD_W)  per-port lane enables; 1 means the lane is written.
- ack  out  NUM_PORTS  one-hot, 1-cycle completion pulse to the granted port.
- rd_data  out  DATA_W  shared read data; valid while ack is high for a read.
- busy  out  1  high in BUSY.
- gnt_id  out  3  port currently or last serviced.

## Operation

State machine: IDLE, BUSY.

**IDLE**
- Request vector req[p] = re[p] | we[p].
- If any req bit is set, pick the winner round-robin: search starts at (last_gnt+1) mod NUM_PORTS.
- On the edge, capture the winner's addr, wdata, wmask and op into internal registers.
- Op rule: we has priority over re on the same port, i.e. op = write if we[p], else read.
- Set last_gnt and gnt_id to the winner, clear cnt to 0, go to BUSY.
- If no request, stay in IDLE.

**BUSY**
- cnt increments every cycle.
- On the edge where cnt goes LATENCY-2 → LATENCY-1, perform the access using captured values:
  - write: mem[addr] lanes with wmask=1 are updated, other lanes hold; rd_data is unchanged.
  - read: rd_data <= mem[addr].
- While cnt == LATENCY-1: ack[gnt] = 1 (combinational from state/cnt). On the next edge go to IDLE.

**Requester rules**
- Hold re/we, addr, wdata and wmask stable until it samples its ack.
- Deassert, or issue a new request, in the cycle after ack.
- Inputs that change after the capture edge are ignored.

**Boundary conditions**
- addr ≥ DEPTH: a write is dropped; a read returns rd_data = 0. ack still pulses normally.
- wmask all zero on a write: no memory change; ack still pulses.
- Requests arriving while BUSY wait; nothing is queued beyond the held inputs.
- Requests from all ports continuously asserted: service order is p, p+1, ... cyclically. No port waits more than NUM_PORTS accesses.

**Reset**
- Takes priority over everything at the edge.
- state = IDLE, cnt = 0, last_gnt = NUM_PORTS-1 (so port 0 has first priority), gnt_id = 0, rd_data = 0.
- An in-flight access is aborted; if rst coincides with the access edge, no write occurs.
- Memory array contents are not reset.

## Timing

- Reset values: ack = 0, busy = 0, rd_data = 0, gnt_id = 0.
- Request sampled in cycle T (IDLE). Memory is updated and rd_data is loaded at the end of cycle T+LATENCY-1. ack is high during cycle T+LATENCY only.
- Next arbitration happens in cycle T+LATENCY+1. Back-to-back throughput: one access per LATENCY+1 cycles.
- A read issued immediately after a write to the same address returns the new data.
- busy is high for exactly LATENCY cycles per access.
- ack is never high for more than one cycle or on more than one port.

## Test plan

1. **Reset.** Hold rst 2 cycles with re[0]=1 -> ack=0, busy=0, rd_data=0. After release, the port 0 request is accepted on the first edge.
2. **Single-port latency.** Port 0: write addr 0x010, data 0x1111_2222_3333_4444, wmask 4'hF in cycle T -> ack[0] high in cycle T+4 only. Then a read of 0x010 -> rd_data=0x1111_2222_3333_4444 during its ack cycle.
3. **Masked write.** Line 0x010 = 0x1111_2222_3333_4444; write 0xAAAA_BBBB_CCCC_DDDD with wmask 4'b0101 -> readback 0x1111_BBBB_3333_DDDD.
4. **Arbitration.** Ports 0 and 1 request continuously from the same cycle -> grants alternate 0,1,0,1; acks spaced 5 cycles apart; gnt_id tracks the grant.
5. **Out of range and re+we.** With DEPTH=1000:
   - write to addr 1500 -> ack pulses, no array change.
   - read of 1500 -> rd_data=0.
   - re=we=1 on a port -> treated as a write, rd_data unchanged.
6. **Reset mid-access.** Assert rst in the cycle where cnt=2 of a write to 0x020 -> no ack. A subsequent read of 0x020 returns its prior value.
